// File: rtl/plic_claim_dispatcher_pkg.sv
// Shared types and constants for the PLIC claim/complete dispatcher.
// Register-bus request/response structs, FSM state encodings and the default claim address.
package plic_claim_dispatcher_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  // Context-0 base plus the claim/complete register offset.
  localparam logic [AddrWidth-1:0] CtxBase       = 32'h0020_0000;
  localparam logic [AddrWidth-1:0] CcOffset      = 32'h0000_0004;
  localparam logic [AddrWidth-1:0] DefaultCcAddr = CtxBase + CcOffset;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StClaim    = 3'd1;
  localparam state_t StDeliver  = 3'd2;
  localparam state_t StService  = 3'd3;
  localparam state_t StComplete = 3'd4;

endpackage

// File: rtl/plic_claim_dispatcher.sv
// Claim/complete agent for one PLIC context: claims on irq, hands the ID to a consumer, completes.
// Define PLIC_CLAIM_DISPATCHER_SPURIOUS_CNT_EN to build the saturating spurious-claim counter.
module plic_claim_dispatcher
  import plic_claim_dispatcher_pkg::*;
#(
  parameter int unsigned           SrcW    = 7,
  parameter logic [AddrWidth-1:0]  CcAddr  = DefaultCcAddr,
  parameter int unsigned           Holdoff = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            irq_i,
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic [SrcW-1:0] id_o,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            err_o,
  output logic [15:0]     spurious_cnt_o
);

  localparam int unsigned HoW = $clog2(Holdoff + 1);

  state_t                 state_q, state_d;
  logic [SrcW-1:0]        id_q, id_d;
  logic                   idv_q, busy_q, err_q, err_d;
  logic [HoW-1:0]         hold_q, hold_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
  logic                   spur_inc;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    err_d    = 1'b0;
    hold_d   = hold_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    spur_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (irq_i && enable_i) begin
          state_d = StClaim;
          addr_d  = CcAddr;
          write_d = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
        end
      end
      StClaim: begin
        if (reg_rsp_i.ready) begin
          addr_d = '0;
          if (reg_rsp_i.error) begin
            err_d   = 1'b1;
            state_d = StIdle;
            hold_d  = HoW'(Holdoff);
          end else if (reg_rsp_i.rdata[SrcW-1:0] == '0) begin
            spur_inc = 1'b1;
            state_d  = StIdle;
            hold_d   = HoW'(Holdoff);
          end else begin
            id_d    = reg_rsp_i.rdata[SrcW-1:0];
            state_d = StDeliver;
          end
        end
      end
      StDeliver: begin
        if (id_ready_i) state_d = StService;
      end
      StService: begin
        if (done_i) begin
          state_d = StComplete;
          addr_d  = CcAddr;
          write_d = 1'b1;
          wdata_d = DataWidth'(id_q);
          wstrb_d = '1;
        end
      end
      StComplete: begin
        if (reg_rsp_i.ready) begin
          err_d   = reg_rsp_i.error;
          state_d = StIdle;
          hold_d  = HoW'(Holdoff);
          addr_d  = '0;
          write_d = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      id_q    <= '0;
      idv_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idv_q   <= (state_d == StDeliver);
      busy_q  <= (state_d != StIdle);
      err_q   <= err_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // valid comes straight from the state so reset drops it without waiting for a clock.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q == StClaim) || (state_q == StComplete);
  end

  assign id_o       = id_q;
  assign id_valid_o = idv_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

`ifdef PLIC_CLAIM_DISPATCHER_SPURIOUS_CNT_EN
  logic [15:0] spur_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spur_q <= '0;
    end else if (spur_inc && (spur_q != 16'hFFFF)) begin
      spur_q <= spur_q + 16'd1;
    end
  end

  assign spurious_cnt_o = spur_q;
`else
  logic unused_spur_inc;
  assign unused_spur_inc = spur_inc;
  assign spurious_cnt_o  = '0;
`endif

  logic unused_rdata;
  assign unused_rdata = ^reg_rsp_i.rdata[DataWidth-1:SrcW];

endmodule
